op_dispatch_demux: RTL and testbench
====================================

# op_dispatch_demux

Parametrised, registered 1-to-N dispatch demultiplexer with a valid/ready handshake. It accepts a command (select plus payload) on a single input port and routes it to one of N_CH output channels, with one holding register per channel. In the ALU path it sits between the decode stage and the functional units (ADD, SUB, AND, OR, …), so a stalled unit blocks only commands addressed to that unit.

## Interface
Parameters:
- N_CH, 4: number of output channels, ≥2.
- DATA_W, 8: payload width.
- SEL_W, $clog2(N_CH): select width; derived, not overridden.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  command present.
- in_ready  out  1  command accepted this cycle when in_valid is also high.
- in_sel  in  SEL_W  destination channel.
- in_data  in  DATA_W  payload.
- out_valid  out  N_CH  per-channel payload valid.
- out_ready  in  N_CH  per-channel consumer ready.
- out_data  out  N_CH×DATA_W  packed; channel k occupies bits [k*DATA_W +: DATA_W].
- sel_err  out  1  sticky: an out-of-range in_sel was accepted.
- err_clr  in  1  clears sel_err.
- busy  out  1  OR of out_valid.
- stat_cnt  out  N_CH×16  per-channel accept counters; present only with OP_DISPATCH_STATS_EN.

## Operation
- Each channel slot has two states. EMPTY: out_valid=0. FULL: out_valid=1, out_data held stable.
- Channel k loads when in_valid && in_ready && in_sel==k. A load moves the slot to FULL, or keeps it FULL with the new data.
- Channel k drains when out_valid[k] && out_ready[k]. If it drains without a load in the same cycle, it moves to EMPTY.
- in_ready = !out_valid[in_sel] || out_ready[in_sel]. Load and drain in the same cycle on the same channel is allowed, giving full throughput.
- in_ready depends combinationally on out_ready. Consumers must not make out_ready depend on in_ready.
- Channels other than in_sel are unaffected by the input handshake. Order is preserved per channel.
- Out-of-range select (in_sel ≥ N_CH, possible only when N_CH is not a power of 2):
  - in_ready=1 and the command is dropped.
  - sel_err is set on the next edge.
- err_clr clears sel_err. If err_clr and a new out-of-range accept occur in the same cycle, sel_err stays 1; set wins.
- When in_valid=0, in_ready is still driven from in_sel. Its value is don't-care.

## Timing
- Latency: 1 cycle. A command accepted at edge n appears on out_valid/out_data after edge n.
- Reset values, applied on the first edge with rst=1:
  - out_valid=0 and out_data=0 for all channels.
  - sel_err=0, busy=0, stat_cnt=0.
- Reset mid-operation discards all held payloads. No partial drain.
- While out_valid[k]=1 and out_ready[k]=0, out_data[k] must not change.
- busy is registered-derived: it reflects slot state, not the current input.

## Configuration
- Macro: OP_DISPATCH_STATS_EN.
- Defined:
  - Each channel gets a 16-bit counter that increments on every load of that channel.
  - Counters saturate at 0xFFFF.
  - Counters are cleared only by rst.
  - Dropped out-of-range commands are not counted.
  - stat_cnt is exported.
- Undefined: no counters and no stat_cnt port. All other behaviour is identical.

## Structure
- Package op_dispatch_pkg holds:
  - enum op_ch_e: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3.
  - localparams DEF_N_CH=4 and DEF_DATA_W=8.
  - STAT_W=16.
- Sub-module op_dispatch_slot is instantiated N_CH times. Each instance holds one channel's one-entry register with its load/drain handshake and the optional counter.
- The top level performs select decode, in_ready mux, error flag and busy reduction.

## Test plan
- After reset, in_valid=1, in_sel=2, in_data=0x5A, all out_ready=1:
  - in_ready=1.
  - Next cycle out_valid=4'b0100 and out_data[2]=0x5A.
  - Following cycle out_valid=0.
- Ch 1 stalled (out_ready[1]=0) and FULL; send to ch 1 then ch 3:
  - in_ready=0 for the ch 1 command.
  - The ch 3 command is accepted and out_valid[3]=1, with ch 1 data unchanged.
- Back-to-back 0x01, 0x02, 0x03 to ch 0 with out_ready[0]=1: one accept per cycle, and out_data[0] sequence is 0x01, 0x02, 0x03.
- N_CH=3, in_sel=3:
  - in_ready=1 and no out_valid rises.
  - sel_err=1 the next cycle and holds.
  - err_clr together with another in_sel=3 keeps sel_err=1; err_clr alone clears it.
- rst asserted while ch 0 and ch 2 are FULL and stalled: after the reset edge, out_valid=0 and out_data=0.
- With OP_DISPATCH_STATS_EN: 70000 loads to ch 1 give stat_cnt[1]=0xFFFF and all other counters 0.

Source files
------------

// File: rtl/op_dispatch_pkg.sv
// Shared types and constants for the op_dispatch demultiplexer.
// Only the channel counters (built with OP_DISPATCH_STATS_EN) use STAT_W and sat_inc.
package op_dispatch_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } op_ch_e;

    localparam int DEF_N_CH   = 4;
    localparam int DEF_DATA_W = 8;
    localparam int STAT_W     = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/op_dispatch_slot.sv
// One-entry holding register for a single dispatch channel, with load/drain handshake.
// With OP_DISPATCH_STATS_EN defined it also keeps a saturating accept counter.
module op_dispatch_slot
    import op_dispatch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
`ifdef OP_DISPATCH_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_cnt
`endif
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // A load wins over a drain so a simultaneous load/drain keeps the slot FULL.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

`ifdef OP_DISPATCH_STATS_EN
    logic [STAT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stat_cnt = cnt_q;
`endif

endmodule

// File: rtl/op_dispatch_demux.sv
// Registered 1-to-N_CH dispatch demultiplexer with per-channel valid/ready slots.
// Optional per-channel accept counters are enabled by defining OP_DISPATCH_STATS_EN.
module op_dispatch_demux
    import op_dispatch_pkg::*;
#(
    parameter  int N_CH   = DEF_N_CH,
    parameter  int DATA_W = DEF_DATA_W,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic [DATA_W-1:0]        in_data,
    output logic [N_CH-1:0]          out_valid,
    input  logic [N_CH-1:0]          out_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic                     sel_err,
    input  logic                     err_clr,
    output logic                     busy
`ifdef OP_DISPATCH_STATS_EN
    ,
    output logic [N_CH*STAT_W-1:0]   stat_cnt
`endif
);

    logic [N_CH-1:0] load;
    logic            sel_hit;
    logic            oob_accept;
    logic            sel_err_q, sel_err_d;

    // An out-of-range select matches no slot, so in_ready stays 1 and the command is dropped.
    always_comb begin
        in_ready = 1'b1;
        sel_hit  = 1'b0;
        load     = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_hit  = 1'b1;
                in_ready = !out_valid[k] || out_ready[k];
            end
        end
        for (int k = 0; k < N_CH; k++) begin
            load[k] = in_valid && in_ready && (in_sel == SEL_W'(k));
        end
        oob_accept = in_valid && !sel_hit;
        sel_err_d  = sel_err_q;
        if (oob_accept) begin
            sel_err_d = 1'b1;
        end else if (err_clr) begin
            sel_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_slot
        op_dispatch_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (load[k]),
            .load_data(in_data),
            .out_ready(out_ready[k]),
            .out_valid(out_valid[k]),
            .out_data (out_data[k*DATA_W +: DATA_W])
`ifdef OP_DISPATCH_STATS_EN
            ,
            .stat_cnt (stat_cnt[k*STAT_W +: STAT_W])
`endif
        );
    end

    assign sel_err = sel_err_q;
    assign busy    = |out_valid;

endmodule

// File: tb/tb_op_dispatch_demux.sv
// Scoreboard bench for op_dispatch_demux: 4-channel instance with random traffic plus a
// 3-channel instance for out-of-range select handling. Counters checked with OP_DISPATCH_STATS_EN.
module tb_op_dispatch_demux;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, err_clr, sel_err, busy;
    logic [1:0]  in_sel;
    logic [7:0]  in_data;
    logic [3:0]  out_valid, out_ready;
    logic [31:0] out_data;

    logic        in_valid3, in_ready3, err_clr3, sel_err3, busy3;
    logic [1:0]  in_sel3;
    logic [7:0]  in_data3;
    logic [2:0]  out_valid3, out_ready3;
    logic [23:0] out_data3;

`ifdef OP_DISPATCH_STATS_EN
    logic [63:0] stat_cnt;
    logic [47:0] stat_cnt3;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: per-channel occupancy, expected payload order and load counts.
    logic       full_m [4];
    int         ld_cnt [4];
    logic [7:0] exp_q  [4][$];

    always #5 clk = ~clk;

    op_dispatch_demux #(.N_CH(4), .DATA_W(8)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sel_err(sel_err), .err_clr(err_clr), .busy(busy)
`ifdef OP_DISPATCH_STATS_EN
        , .stat_cnt(stat_cnt)
`endif
    );

    op_dispatch_demux #(.N_CH(3), .DATA_W(8)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_sel(in_sel3), .in_data(in_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .sel_err(sel_err3), .err_clr(err_clr3), .busy(busy3)
`ifdef OP_DISPATCH_STATS_EN
        , .stat_cnt(stat_cnt3)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat16(input int n);
        return (n > 65535) ? 16'hFFFF : 16'(n);
    endfunction

    // One clock of stimulus to the 4-channel DUT; the model decides acceptance from the
    // handshake rule and queues the payload for the monitor.
    task automatic step(input logic v, input logic [1:0] s, input logic [7:0] d,
                        input logic [3:0] r);
        logic exp_rdy;
        @(negedge clk);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #1;
        exp_rdy = !full_m[s] || r[s];
        if (v) check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        for (int k = 0; k < 4; k++) begin
            if (v && exp_rdy && (int'(s) == k)) begin
                full_m[k] = 1'b1;
                exp_q[k].push_back(d);
                ld_cnt[k]++;
            end else if (full_m[k] && r[k]) begin
                full_m[k] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_valid3 = 1'b0;
        err_clr3  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            full_m[k] = 1'b0;
            ld_cnt[k] = 0;
            exp_q[k].delete();
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every held payload must match the oldest outstanding one for its channel.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                for (int k = 0; k < 4; k++) begin
                    if (exp_q[k].size() == 0) begin
                        check($sformatf("out_valid_idle[%0d]", k), {31'd0, out_valid[k]}, 32'd0);
                    end else if (out_valid[k]) begin
                        check($sformatf("out_data[%0d]", k), {24'd0, out_data[k*8 +: 8]},
                              {24'd0, exp_q[k][0]});
                        if (out_ready[k]) void'(exp_q[k].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0; err_clr = 1'b0;
        in_valid3 = 1'b0; in_sel3 = '0; in_data3 = '0; out_ready3 = '0; err_clr3 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            full_m[k] = 1'b0;
            ld_cnt[k] = 0;
        end
        do_reset();
        #1;
        check("rst_out_valid", {28'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sel_err", {31'd0, sel_err}, 32'd0);
        check("rst_out_valid3", {29'd0, out_valid3}, 32'd0);

`ifdef OP_DISPATCH_STATS_EN
        for (int i = 0; i < 70000; i++) step(1'b1, 2'd1, 8'(i), 4'hF);
        step(1'b0, 2'd0, 8'd0, 4'hF);
        for (int k = 0; k < 4; k++)
            check($sformatf("stat_sat[%0d]", k), {16'd0, stat_cnt[k*16 +: 16]}, {16'd0, sat16(ld_cnt[k])});
        do_reset();
        #1;
        check("rst_stat_cnt", stat_cnt[31:0] | stat_cnt[63:32], 32'd0);
`endif

        // Single dispatch to channel 2
        step(1'b1, 2'd2, 8'h5A, 4'hF);
        step(1'b0, 2'd0, 8'h00, 4'hF);
        check("ch2_valid", {28'd0, out_valid}, 32'h4);
        check("ch2_data", {24'd0, out_data[23:16]}, 32'h5A);
        check("ch2_busy", {31'd0, busy}, 32'd1);
        step(1'b0, 2'd0, 8'h00, 4'hF);
        check("ch2_drained", {28'd0, out_valid}, 32'd0);

        // Channel 1 stalled: its command waits, channel 3 proceeds
        step(1'b1, 2'd1, 8'h11, 4'b1101);
        step(1'b1, 2'd1, 8'h22, 4'b1101);
        step(1'b1, 2'd3, 8'h33, 4'b1101);
        step(1'b0, 2'd0, 8'h00, 4'b1101);
        check("stall_ch3_valid", {31'd0, out_valid[3]}, 32'd1);
        check("stall_ch1_data", {24'd0, out_data[15:8]}, 32'h11);
        step(1'b0, 2'd0, 8'h00, 4'hF);

        // Back-to-back to channel 0
        step(1'b1, 2'd0, 8'h01, 4'hF);
        step(1'b1, 2'd0, 8'h02, 4'hF);
        check("b2b_1", {24'd0, out_data[7:0]}, 32'h01);
        step(1'b1, 2'd0, 8'h03, 4'hF);
        check("b2b_2", {24'd0, out_data[7:0]}, 32'h02);
        step(1'b0, 2'd0, 8'h00, 4'hF);
        check("b2b_3", {24'd0, out_data[7:0]}, 32'h03);
        step(1'b0, 2'd0, 8'h00, 4'hF);

        // Out-of-range select on the 3-channel instance
        step(1'b0, 2'd0, 8'h00, 4'hF);
        in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 8'hEE; out_ready3 = 3'b111;
        #1;
        check("oob_in_ready", {31'd0, in_ready3}, 32'd1);
        step(1'b0, 2'd0, 8'h00, 4'hF);
        in_valid3 = 1'b0;
        #1;
        check("oob_no_valid", {29'd0, out_valid3}, 32'd0);
        check("oob_sel_err", {31'd0, sel_err3}, 32'd1);
        step(1'b0, 2'd0, 8'h00, 4'hF);
        #1;
        check("oob_sel_err_hold", {31'd0, sel_err3}, 32'd1);
        step(1'b0, 2'd0, 8'h00, 4'hF);
        err_clr3 = 1'b1; in_valid3 = 1'b1; in_sel3 = 2'd3;
        step(1'b0, 2'd0, 8'h00, 4'hF);
        err_clr3 = 1'b0; in_valid3 = 1'b0;
        #1;
        check("oob_set_wins", {31'd0, sel_err3}, 32'd1);
        step(1'b0, 2'd0, 8'h00, 4'hF);
        err_clr3 = 1'b1;
        step(1'b0, 2'd0, 8'h00, 4'hF);
        err_clr3 = 1'b0;
        #1;
        check("oob_cleared", {31'd0, sel_err3}, 32'd0);
        step(1'b0, 2'd0, 8'h00, 4'hF);
        in_valid3 = 1'b1; in_sel3 = 2'd2; in_data3 = 8'h77;
        #1;
        check("n3_in_ready", {31'd0, in_ready3}, 32'd1);
        step(1'b0, 2'd0, 8'h00, 4'hF);
        in_valid3 = 1'b0;
        #1;
        check("n3_valid", {29'd0, out_valid3}, 32'h4);
        check("n3_data", {24'd0, out_data3[23:16]}, 32'h77);

        // Reset while channels 0 and 2 hold stalled payloads
        step(1'b1, 2'd0, 8'hA1, 4'b0000);
        step(1'b1, 2'd2, 8'hA2, 4'b0000);
        step(1'b0, 2'd0, 8'h00, 4'b0000);
        check("pre_rst_valid", {28'd0, out_valid}, 32'h5);
        do_reset();
        #1;
        check("midrst_valid", {28'd0, out_valid}, 32'd0);
        check("midrst_data", out_data, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom), 8'($urandom),
                 4'($urandom | $urandom));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 8'h00, 4'hF);
        for (int k = 0; k < 4; k++)
            check($sformatf("drained[%0d]", k), 32'(exp_q[k].size()), 32'd0);
        check("final_sel_err", {31'd0, sel_err}, 32'd0);
`ifdef OP_DISPATCH_STATS_EN
        for (int k = 0; k < 4; k++)
            check($sformatf("stat_cnt[%0d]", k), {16'd0, stat_cnt[k*16 +: 16]}, {16'd0, sat16(ld_cnt[k])});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
